// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2R1W register file with pending-write scoreboard and post-reset clear; optional write-to-read bypass under REGFILE_BYPASS_EN.
// Reads and writes take effect on one edge; no backpressure, requests are ignored until ready.
`timescale 1ns/100ps
module regfile_2r1w_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  output logic              rvalid,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_run;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_wa;
  logic [DATA_W-1:0] w_mem_wd;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_pending_nxt;

  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_busy1;
  logic              r_busy2;
  logic              r_rvalid;

  logic [DATA_W-1:0] w_rd1_dat;
  logic [DATA_W-1:0] w_rd2_dat;
  logic              w_rd1_busy;
  logic              w_rd2_busy;
  logic              w_rd_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // CLEAR owns the array write port; RUN hands it to writeback.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_run       = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wa    = wa;
    w_mem_wd    = wdata;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we  = 1'b1;
        w_mem_wa  = r_cnt;
        w_mem_wd  = '0;
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run    = 1'b1;
        w_mem_we = we;
      end
    endcase
  end

  assign ready = w_run;

  // Array has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      r_mem[w_mem_wa] <= w_mem_wd;
    end
  end

  // Set is applied after clear so an issue and a writeback to one register leave it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_run && we) begin
      w_pending_nxt[wa] = 1'b0;
    end
    if (w_run && sb_set) begin
      w_pending_nxt[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    w_rd1_dat  = r_mem[ra1];
    w_rd1_busy = r_pending[ra1];
    w_rd2_dat  = r_mem[ra2];
    w_rd2_busy = r_pending[ra2];
    if (we && (wa == ra1)) begin
      w_rd1_dat  = wdata;
      w_rd1_busy = sb_set && (sb_addr == wa);
    end
    if (we && (wa == ra2)) begin
      w_rd2_dat  = wdata;
      w_rd2_busy = sb_set && (sb_addr == wa);
    end
  end
`else
  always_comb begin
    w_rd1_dat  = r_mem[ra1];
    w_rd1_busy = r_pending[ra1];
    w_rd2_dat  = r_mem[ra2];
    w_rd2_busy = r_pending[ra2];
  end
`endif

  assign w_rd_fire = w_run && rd_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_busy1  <= 1'b0;
      r_busy2  <= 1'b0;
      r_rvalid <= 1'b0;
    end else if (w_rd_fire) begin
      r_rdata1 <= w_rd1_dat;
      r_rdata2 <= w_rd2_dat;
      r_busy1  <= w_rd1_busy;
      r_busy2  <= w_rd2_busy;
      r_rvalid <= 1'b1;
    end else begin
      r_rvalid <= 1'b0;
    end
  end

  assign rdata1 = r_rdata1;
  assign rdata2 = r_rdata2;
  assign busy1  = r_busy1;
  assign busy2  = r_busy2;
  assign rvalid = r_rvalid;

endmodule
